// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the trigger-board serial command protocol:
// opcodes, master FSM states and per-opcode argument/response shapes.
package serial_cmd_pkg;

  localparam logic [7:0] CMD_VERSION   = 8'd0;
  localparam logic [7:0] CMD_COINC     = 8'd1;
  localparam logic [7:0] CMD_HISTSEL   = 8'd2;
  localparam logic [7:0] CMD_OUTEN     = 8'd3;
  localparam logic [7:0] CMD_CLKSW     = 8'd4;
  localparam logic [7:0] CMD_PHASE_ALL = 8'd5;
  localparam logic [7:0] CMD_SEED      = 8'd6;
  localparam logic [7:0] CMD_PRESCALE  = 8'd7;
  localparam logic [7:0] CMD_ACTCLK    = 8'd8;
  localparam logic [7:0] CMD_UPDOWN    = 8'd9;
  localparam logic [7:0] CMD_HISTO     = 8'd10;
  localparam logic [7:0] CMD_DEAD      = 8'd11;
  localparam logic [7:0] CMD_PHASE_C1  = 8'd12;
  localparam logic [7:0] CMD_ROLLING   = 8'd13;

  localparam logic [2:0] MAX_ARGS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_LOAD,
    ST_TX_HOLD,
    ST_RX_WAIT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [2:0] nargs;
    logic [5:0] nresp;
  } cmd_shape_t;

  // Argument/response byte counts the trigger board expects for each opcode.
  function automatic cmd_shape_t cmd_shape(input logic [7:0] op);
    cmd_shape_t s;
    s.nargs = 3'd0;
    s.nresp = 6'd0;
    case (op)
      CMD_COINC, CMD_HISTSEL, CMD_DEAD: s.nargs = 3'd1;
      CMD_SEED, CMD_PRESCALE:           s.nargs = 3'd4;
      CMD_VERSION, CMD_ACTCLK:          s.nresp = 6'd1;
      CMD_HISTO:                        s.nresp = 6'd32;
      default: begin
        s.nargs = 3'd0;
        s.nresp = 6'd0;
      end
    endcase
    return s;
  endfunction

  function automatic logic [2:0] clamp_nargs(input logic [2:0] n);
    return (n > MAX_ARGS) ? MAX_ARGS : n;
  endfunction

  function automatic logic [5:0] clamp_nresp(input logic [5:0] n, input logic [5:0] maxr);
    return (n > maxr) ? maxr : n;
  endfunction

endpackage

// File: rtl/serial_cmd_master.sv
// Host-side command initiator: sends opcode plus arguments through a UART TX
// handshake, then collects a fixed number of response bytes with timeout.
module serial_cmd_master
  import serial_cmd_pkg::*;
#(
  parameter int MAXRESP = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [2:0]  cmd_nargs,
  input  logic [31:0] cmd_args,
  input  logic [5:0]  cmd_nresp,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        rxReady,
  input  logic [7:0]  rxData,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic [4:0]  resp_index,
  output logic        done,
  output logic        timeout,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT);
  // Expiry is decided one cycle early so done lands exactly TIMEOUT cycles
  // after the reference event.
  localparam logic [CW-1:0] EXPIRE    = CW'(TIMEOUT - 2);
  localparam logic [5:0]    MAXRESP_C = 6'(MAXRESP);

  state_e         state_q;
  logic [7:0]     op_q;
  logic [31:0]    args_q;
  logic [2:0]     nargs_q;
  logic [5:0]     nresp_q;
  logic [2:0]     idx_q;
  logic [5:0]     rxcnt_q;
  logic [CW-1:0]  tcnt_q;
  logic [7:0]     tx_byte_d;

  logic           cmd_ready_q;
  logic           txStart_q;
  logic [7:0]     txData_q;
  logic           resp_valid_q;
  logic [7:0]     resp_data_q;
  logic [4:0]     resp_index_q;
  logic           done_q;
  logic           timeout_q;
  logic           busy_q;

  always_comb begin
    tx_byte_d = op_q;
    case (idx_q)
      3'd1:    tx_byte_d = args_q[7:0];
      3'd2:    tx_byte_d = args_q[15:8];
      3'd3:    tx_byte_d = args_q[23:16];
      3'd4:    tx_byte_d = args_q[31:24];
      default: tx_byte_d = op_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      rxcnt_q      <= 6'd0;
      tcnt_q       <= '0;
      cmd_ready_q  <= 1'b1;
      txStart_q    <= 1'b0;
      txData_q     <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'd0;
      resp_index_q <= 5'd0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      txStart_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_opcode;
            args_q      <= cmd_args;
            nargs_q     <= clamp_nargs(cmd_nargs);
            nresp_q     <= clamp_nresp(cmd_nresp, MAXRESP_C);
            idx_q       <= 3'd0;
            rxcnt_q     <= 6'd0;
            timeout_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_TX_LOAD;
          end
        end
        ST_TX_LOAD: begin
          if (!txBusy) begin
            txData_q  <= tx_byte_d;
            txStart_q <= 1'b1;
            state_q   <= ST_TX_HOLD;
          end
        end
        ST_TX_HOLD: begin
          if (idx_q < nargs_q) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= ST_TX_LOAD;
          end else begin
            tcnt_q <= '0;
            if (nresp_q != 6'd0) begin
              state_q <= ST_RX_WAIT;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        // Completion is checked before rxReady so a byte beyond nresp is never
        // presented; a byte on the expiry cycle beats the timeout.
        ST_RX_WAIT: begin
          if (rxcnt_q == nresp_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (rxReady) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= rxData;
            resp_index_q <= rxcnt_q[4:0];
            rxcnt_q      <= rxcnt_q + 6'd1;
            tcnt_q       <= '0;
          end else if (tcnt_q == EXPIRE) begin
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          timeout_q   <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign txStart    = txStart_q;
  assign txData     = txData_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_index = resp_index_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_cmd_master.sv
// Randomised bench for serial_cmd_master with a UART TX/RX model and a
// transaction-level reference for byte sequences, responses and completion time.
module tb_serial_cmd_master;
  import serial_cmd_pkg::*;

  localparam int TO = 100;
  localparam int MR = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode = 8'd0;
  logic [2:0]  cmd_nargs = 3'd0;
  logic [31:0] cmd_args = 32'd0;
  logic [5:0]  cmd_nresp = 6'd0;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic        rxReady = 1'b0;
  logic [7:0]  rxData = 8'd0;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic [4:0]  resp_index;
  logic        done;
  logic        timeout;
  logic        busy;

  serial_cmd_master #(.MAXRESP(MR), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_nargs(cmd_nargs), .cmd_args(cmd_args), .cmd_nresp(cmd_nresp),
    .txBusy(txBusy), .txStart(txStart), .txData(txData),
    .rxReady(rxReady), .rxData(rxData),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_index(resp_index),
    .done(done), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART TX model: busy for 2..6 cycles starting the cycle after txStart.
  int   ucnt = 0;
  logic force_busy = 1'b0;
  assign txBusy = force_busy || (ucnt != 0);
  always @(negedge clk) begin
    if (!rstn) ucnt = 0;
    else if (txStart) ucnt = $urandom_range(6, 2);
    else if (ucnt != 0) ucnt = ucnt - 1;
  end

  logic [7:0] txq[$];
  logic [7:0] rvd[$];
  int         rvi[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       done_to = 1'b0;
  int         first_txs = -1;
  int         last_txs = 0;

  always @(negedge clk) begin
    if (txStart) begin
      txq.push_back(txData);
      if (first_txs < 0) first_txs = cyc;
      last_txs = cyc;
    end
    if (resp_valid) begin
      rvd.push_back(resp_data);
      rvi.push_back(int'(resp_index));
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      done_to  = timeout;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_txStart"}, 32'(txStart), 32'd0);
    chk({tag, "_txData"}, 32'(txData), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_resp_index"}, 32'(resp_index), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic clear_mon();
    txq.delete();
    rvd.delete();
    rvi.delete();
    done_cnt  = 0;
    first_txs = -1;
  endtask

  task automatic submit(input logic [7:0] op, input logic [2:0] na, input logic [31:0] args,
                        input logic [5:0] nr);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_nargs  = na;
    cmd_args   = args;
    cmd_nresp  = nr;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_opcode = 8'($urandom);
    cmd_args   = $urandom;
  endtask

  // gapmode: 0 random spacing, 1 next byte on the last legal cycle, 2 one cycle too late.
  // dmode: 0 random data, 1 data equals index, 2 constant 0x07.
  task automatic run_cmd(input logic [7:0] op, input logic [2:0] na, input logic [31:0] args,
                         input logic [5:0] nr, input int nret, input int bp,
                         input int gapmode, input bit stray, input int dmode);
    int         na_c, nr_c, ntx, tmo, gap, acc, refc, exp_done, rel, bad;
    logic       exp_to;
    logic [7:0] hold;
    logic [7:0] exp_tx[$];
    logic [7:0] rxb[$];
    int         rxcyc[$];

    na_c = (na > 3'd4) ? 4 : int'(na);
    nr_c = (int'(nr) > MR) ? MR : int'(nr);
    ntx  = na_c + 1;
    exp_tx.push_back(op);
    for (int i = 0; i < na_c; i++) exp_tx.push_back(args[8*i +: 8]);
    for (int k = 0; k < nret; k++)
      rxb.push_back((dmode == 1) ? 8'(k) : (dmode == 2) ? 8'h07 : 8'($urandom));

    clear_mon();
    if (bp > 0) force_busy = 1'b1;
    submit(op, na, args, nr);

    if (bp > 0) begin
      hold = txData;
      bad  = 0;
      repeat (bp) begin
        if (txStart || txData !== hold) bad++;
        @(negedge clk);
      end
      chk("bp_quiet", 32'(bad), 32'd0);
      force_busy = 1'b0;
      rel = cyc;
    end

    tmo = 0;
    while (txq.size() < ntx && tmo < 5000) begin
      rxReady = stray && ($urandom_range(2, 0) == 0);
      rxData  = 8'($urandom);
      @(negedge clk);
      tmo++;
    end
    rxReady = 1'b0;
    chk("tx_in_time", 32'(tmo < 5000), 32'd1);
    if (bp > 0) chk("bp_first_start", 32'(first_txs), 32'(rel + 1));
    chk("tx_count", 32'(txq.size()), 32'(ntx));
    for (int i = 0; i < ntx && i < txq.size(); i++) chk("tx_byte", 32'(txq[i]), 32'(exp_tx[i]));
    @(negedge clk);

    for (int k = 0; k < nret; k++) begin
      if (done_cnt != 0) break;
      if (k == 0) gap = $urandom_range(5, 0);
      else if (gapmode == 1) gap = TO - 2;
      else if (gapmode == 2) gap = TO - 1;
      else gap = $urandom_range(20, 0);
      repeat (gap) begin
        rxReady = 1'b0;
        @(negedge clk);
      end
      rxReady = 1'b1;
      rxData  = rxb[k];
      rxcyc.push_back(cyc);
      @(negedge clk);
    end
    rxReady = 1'b0;

    tmo = 0;
    while (done_cnt == 0 && tmo < TO + 50) begin
      @(negedge clk);
      tmo++;
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (2) @(negedge clk);

    acc  = 0;
    refc = last_txs;
    foreach (rxcyc[k]) begin
      if (acc == nr_c) break;
      if (rxcyc[k] - refc >= TO) break;
      acc++;
      refc = rxcyc[k];
    end
    if (nr_c == 0) begin
      exp_done = last_txs + 1;
      exp_to   = 1'b0;
    end else if (acc == nr_c) begin
      exp_done = refc + 2;
      exp_to   = 1'b0;
    end else begin
      exp_done = refc + TO;
      exp_to   = 1'b1;
    end

    chk("resp_count", 32'(rvd.size()), 32'(acc));
    for (int i = 0; i < acc && i < rvd.size(); i++) begin
      chk("resp_data", 32'(rvd[i]), 32'(rxb[i]));
      chk("resp_index", 32'(rvi[i]), 32'(i));
    end
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("done_timeout", 32'(done_to), 32'(exp_to));
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("idle_after", 32'(cmd_ready), 32'd1);
  endtask

  task automatic reset_mid(input logic [7:0] op, input logic [2:0] na, input logic [5:0] nr,
                           input int after_tx, input int after_rx, input string tag);
    int tmo;
    clear_mon();
    submit(op, na, $urandom, nr);
    tmo = 0;
    while (txq.size() < after_tx && tmo < 2000) begin
      @(negedge clk);
      tmo++;
    end
    chk({tag, "_reached"}, 32'(tmo < 2000), 32'd1);
    if (after_rx > 0) begin
      @(negedge clk);
      for (int k = 0; k < after_rx; k++) begin
        rxReady = 1'b1;
        rxData  = 8'($urandom);
        @(negedge clk);
        rxReady = 1'b0;
        @(negedge clk);
      end
      chk({tag, "_partial_resp"}, 32'(rvd.size()), 32'(after_rx));
    end
    rstn = 1'b0;
    @(negedge clk);
    chk_reset(tag);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_no_done"}, 32'(done_cnt), 32'd0);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rstn = 1'b1;
    @(negedge clk);

    run_cmd(CMD_VERSION, 3'd0, 32'd0, 6'd1, 1, 0, 0, 1'b0, 2);
    run_cmd(CMD_SEED, 3'd4, 32'h12345678, 6'd0, 0, 0, 0, 1'b0, 0);
    run_cmd(CMD_HISTO, 3'd0, 32'd0, 6'd32, 32, 0, 0, 1'b0, 1);
    run_cmd(CMD_VERSION, 3'd0, 32'd0, 6'd2, 1, 0, 0, 1'b0, 0);
    run_cmd(CMD_VERSION, 3'd0, 32'd0, 6'd2, 2, 0, 1, 1'b0, 0);
    run_cmd(CMD_VERSION, 3'd0, 32'd0, 6'd2, 2, 0, 2, 1'b0, 0);
    run_cmd(CMD_ACTCLK, 3'd0, 32'd0, 6'd1, 0, 0, 0, 1'b0, 0);
    run_cmd(CMD_PRESCALE, 3'd4, $urandom, 6'd0, 0, 50, 0, 1'b0, 0);
    run_cmd(CMD_SEED, 3'd4, $urandom, 6'd3, 3, 0, 0, 1'b1, 0);
    run_cmd(CMD_COINC, 3'd7, $urandom, 6'd63, 32, 0, 0, 1'b1, 0);

    reset_mid(CMD_SEED, 3'd4, 6'd0, 2, 0, "rst_args");
    reset_mid(CMD_HISTO, 3'd0, 6'd32, 1, 5, "rst_resp");

    for (int it = 0; it < 20; it++) begin
      logic [7:0] op;
      cmd_shape_t sh;
      logic [2:0] na;
      logic [5:0] nr;
      int         nrc;
      int         nret;
      op = 8'($urandom_range(13, 0));
      sh = cmd_shape(op);
      na = sh.nargs;
      nr = sh.nresp;
      if ($urandom_range(3, 0) == 0) begin
        na = 3'($urandom);
        nr = 6'($urandom);
      end
      nrc  = (int'(nr) > MR) ? MR : int'(nr);
      nret = nrc;
      if (nrc > 0 && $urandom_range(4, 0) == 0) nret = $urandom_range(nrc - 1, 0);
      run_cmd(op, na, $urandom, nr, nret, 0, 0, 1'($urandom_range(1, 0)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
